// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared widths, FSM state type and priority search for rr_arbiter_4
package rr_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ... mod N_REQ.
  // The scan runs from the farthest offset down so the nearest hit is written last.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rtl/rr_arbiter_4_if.sv - requester-facing request/grant bundle for rr_arbiter_4
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  logic              en;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_vld, timeout
  );

endinterface

// File: rtl/decoder_2to4.sv
// rtl/decoder_2to4.sv - 2:4 one-hot decoder with enable; all outputs low when disabled
module decoder_2to4 (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter with hold-until-release grants
// Optional forced release after MAX_HOLD cycles is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_4_if.slave   bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD out of range");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_vld_q;
  logic [IDX_W:0]   pick;

  assign pick = rr_pick(bus.req, ptr);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && pick[IDX_W]) begin
            state     <= BUSY;
            gnt_idx_q <= pick[IDX_W-1:0];
            gnt_vld_q <= 1'b1;
            ptr       <= pick[IDX_W-1:0] + IDX_W'(1);
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          // Enable loss and owner release win over the hold limit, so no pulse then.
          if (!bus.en || !bus.req[gnt_idx_q]) begin
            state     <= IDLE;
            gnt_vld_q <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timeout = timeout_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && pick[IDX_W]) begin
            state     <= BUSY;
            gnt_idx_q <= pick[IDX_W-1:0];
            gnt_vld_q <= 1'b1;
            ptr       <= pick[IDX_W-1:0] + IDX_W'(1);
          end
        end
        BUSY: begin
          if (!bus.en || !bus.req[gnt_idx_q]) begin
            state     <= IDLE;
            gnt_vld_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;

  // Decoding registered state keeps gnt free of any combinational path from req.
  decoder_2to4 u_dec (
    .in  (gnt_idx_q),
    .en  (gnt_vld_q),
    .out (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - self-checking bench for rr_arbiter_4 (directed table, corner sequences, random vs model)
module tb_rr_arbiter_4;

  localparam int TB_MAX_HOLD = 8;

  logic clk;
  logic rst;
  rr_arbiter_4_if bus();

  rr_arbiter_4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference: who owns the resource, who is next in line, how long it has held.
  int   m_owner;
  int   m_ptr;
  int   m_held;
  logic m_timeout;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[25];

  task automatic mdl_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_timeout = 1'b0;
  endtask

  task automatic mdl_edge(input logic e, input logic [3:0] r);
    int cand;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      if (e && r != 4'b0000) begin
        for (int k = 3; k >= 0; k--) begin
          cand = (m_ptr + k) % 4;
          if (r[cand]) m_owner = cand;
        end
        m_ptr  = (m_owner + 1) % 4;
        m_held = 1;
      end
    end else if (!e || !r[m_owner]) begin
      m_owner = -1;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_held >= TB_MAX_HOLD) begin
        m_owner   = -1;
        m_timeout = 1'b1;
      end else begin
        m_held = m_held + 1;
      end
`else
      m_held = m_held + 1;
`endif
    end
  endtask

  task automatic apply(input logic e, input logic [3:0] r);
    bus.en  = e;
    bus.req = r;
    @(posedge clk);
    mdl_edge(e, r);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic ev,
                       input logic [1:0] ei, input logic et, input logic idx_always);
    n_vec++;
    if (bus.gnt !== eg || bus.gnt_vld !== ev || bus.timeout !== et ||
        ((ev || idx_always) && bus.gnt_idx !== ei)) begin
      n_err++;
      $display("FAIL %s: got gnt=%b vld=%b idx=%0d timeout=%b, want gnt=%b vld=%b idx=%0d timeout=%b",
               name, bus.gnt, bus.gnt_vld, bus.gnt_idx, bus.timeout, eg, ev, ei, et);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    check(name, eg, m_owner >= 0, ei, m_timeout, 1'b0);
  endtask

  initial begin
    logic [3:0] rq;
    logic       ee;
    n_vec = 0;
    n_err = 0;
    mdl_reset();

    // en, req, expected gnt, expected idx; starts from ptr=0, IDLE
    tbl[0]  = '{1'b1, 4'b0010, 4'b0010, 2'd1};
    tbl[1]  = '{1'b1, 4'b0010, 4'b0010, 2'd1};
    tbl[2]  = '{1'b1, 4'b0010, 4'b0010, 2'd1};
    tbl[3]  = '{1'b1, 4'b0010, 4'b0010, 2'd1};
    tbl[4]  = '{1'b1, 4'b1011, 4'b0010, 2'd1};
    tbl[5]  = '{1'b1, 4'b1101, 4'b0000, 2'd0};
    tbl[6]  = '{1'b1, 4'b1101, 4'b0100, 2'd2};
    tbl[7]  = '{1'b1, 4'b1011, 4'b0000, 2'd0};
    tbl[8]  = '{1'b1, 4'b1111, 4'b1000, 2'd3};
    tbl[9]  = '{1'b1, 4'b0111, 4'b0000, 2'd0};
    tbl[10] = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[11] = '{1'b1, 4'b1110, 4'b0000, 2'd0};
    tbl[12] = '{1'b1, 4'b1111, 4'b0010, 2'd1};
    tbl[13] = '{1'b1, 4'b1101, 4'b0000, 2'd0};
    tbl[14] = '{1'b1, 4'b1111, 4'b0100, 2'd2};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[16] = '{1'b1, 4'b1001, 4'b1000, 2'd3};
    tbl[17] = '{1'b1, 4'b0001, 4'b0000, 2'd0};
    tbl[18] = '{1'b1, 4'b1001, 4'b0001, 2'd0};
    tbl[19] = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[20] = '{1'b1, 4'b0100, 4'b0100, 2'd2};
    tbl[21] = '{1'b0, 4'b1111, 4'b0000, 2'd0};
    tbl[22] = '{1'b0, 4'b1111, 4'b0000, 2'd0};
    tbl[23] = '{1'b1, 4'b1111, 4'b1000, 2'd3};
    tbl[24] = '{1'b1, 4'b0000, 4'b0000, 2'd0};

    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].en, tbl[i].req);
      check($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].gnt != 4'b0000, tbl[i].idx, 1'b0, 1'b0);
    end

    // Asynchronous reset while owner 2 holds the grant
    apply(1'b1, 4'b0100);
    check("pre_rst_grant", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst_async_clear", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    mdl_reset();
    apply(1'b1, 4'b1111);
    check("post_rst_ptr0", 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);

    // Enable drop with owner 2, long disabled window, then resume at ptr=3
    apply(1'b1, 4'b0000);
    check("en_seq_release", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 4'b0100);
    check("en_seq_own2", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
    apply(1'b0, 4'b1111);
    check("en_drop_release", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'b1111);
      check($sformatf("en_low[%0d]", i), 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    end
    apply(1'b1, 4'b1111);
    check("en_resume_ptr3", 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
    apply(1'b1, 4'b0000);
    check("en_resume_release", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Owner 0 keeps requesting with requester 1 waiting
    apply(1'b1, 4'b0011);
    check("hold_grant0", 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      apply(1'b1, 4'b0011);
`ifdef RR_ARB_TIMEOUT_EN
      check_model($sformatf("hold_to[%0d]", i));
`else
      check($sformatf("hold_forever[%0d]", i), 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
`endif
    end
    apply(1'b1, 4'b0000);
    check_model("hold_drop");
    apply(1'b1, 4'b0000);
    check_model("hold_idle");

    // Random traffic; requests tend to persist so grants last several cycles
    rq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      ee = ($urandom_range(0, 15) != 0);
      apply(ee, rq);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
